// File: rtl/window3x3_stream.sv
// Streaming 3x3 neighbourhood generator over a pre-padded raster image.
// Two line buffers plus a 3x3 shift window; valid/ready on both sides, stride 1 or 2.
module window3x3_stream #(
   parameter int PIX_W  = 8,
   parameter int IMG_W  = 256,
   parameter int IMG_H  = 32,
   parameter int STRIDE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PIX_W-1:0]     in_pixel,
   input  logic                 in_sof,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [9*PIX_W-1:0]   out_win,
   output logic                 out_sof,
   output logic                 out_eol,
   output logic                 out_eof,
   output logic                 frame_done,
   output logic                 sof_err,
   input  logic                 err_clr
);

   localparam int IN_W = IMG_W + 2;
   localparam int IN_H = IMG_H + 2;
   localparam int CW   = $clog2(IN_W);
   localparam int RW   = $clog2(IN_H);

   localparam logic [CW-1:0] COL_LAST = CW'(IN_W - 1);
   localparam logic [CW-1:0] COL_EOL  = CW'((STRIDE == 2) ? IN_W - 2 : IN_W - 1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [RW-1:0] ROW_LAST = RW'(IN_H - 1);
   localparam logic [RW-1:0] ROW_EOF  = RW'((STRIDE == 2) ? IN_H - 2 : IN_H - 1);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);

   logic [CW-1:0]    r_col;
   logic [RW-1:0]    r_row;
   logic [PIX_W-1:0] r_lb0 [IN_W];
   logic [PIX_W-1:0] r_lb1 [IN_W];
   logic [PIX_W-1:0] r_top [3];
   logic [PIX_W-1:0] r_mid [3];
   logic [PIX_W-1:0] r_bot [3];
   logic             r_out_valid;
   logic             r_out_sof;
   logic             r_out_eol;
   logic             r_out_eof;
   logic             r_frame_done;
   logic             r_sof_err;

   logic             w_in_ready;
   logic             w_accept;
   logic             w_sof_bad;
   logic [CW-1:0]    w_col;
   logic [RW-1:0]    w_row;
   logic [PIX_W-1:0] w_lb0;
   logic [PIX_W-1:0] w_lb1;
   logic             w_stride_ok;
   logic             w_emit;

   assign w_in_ready = !r_out_valid || out_ready;
   assign w_accept   = in_valid && w_in_ready;
   assign w_sof_bad  = w_accept && in_sof && ((r_col != '0) || (r_row != '0));

   // A start-of-frame pixel is always position (0,0), whatever the counters say.
   assign w_col = in_sof ? '0 : r_col;
   assign w_row = in_sof ? '0 : r_row;

   assign w_lb0 = r_lb0[w_col];
   assign w_lb1 = r_lb1[w_col];

   // For stride 2 the window origin (r-2, c-2) is even exactly when r and c are even.
   assign w_stride_ok = (STRIDE != 2) || (!w_row[0] && !w_col[0]);
   assign w_emit      = (w_row >= ROW_TWO) && (w_col >= COL_TWO) && w_stride_ok;

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_lb1[w_col] <= w_lb0;
         r_lb0[w_col] <= in_pixel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            r_top[i] <= '0;
            r_mid[i] <= '0;
            r_bot[i] <= '0;
         end
      end else if (w_accept) begin
         r_top[0] <= r_top[1];
         r_top[1] <= r_top[2];
         r_top[2] <= w_lb1;
         r_mid[0] <= r_mid[1];
         r_mid[1] <= r_mid[2];
         r_mid[2] <= w_lb0;
         r_bot[0] <= r_bot[1];
         r_bot[1] <= r_bot[2];
         r_bot[2] <= in_pixel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_accept) begin
         if (w_col == COL_LAST) begin
            r_col <= '0;
            r_row <= (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
         end else begin
            r_col <= w_col + 1'b1;
            r_row <= w_row;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_sof    <= 1'b0;
         r_out_eol    <= 1'b0;
         r_out_eof    <= 1'b0;
         r_frame_done <= 1'b0;
         r_sof_err    <= 1'b0;
      end else begin
         r_frame_done <= r_out_valid && out_ready && r_out_eof;
         if (w_accept && w_emit) begin
            r_out_valid <= 1'b1;
            r_out_sof   <= (w_row == ROW_TWO) && (w_col == COL_TWO);
            r_out_eol   <= (w_col == COL_EOL);
            r_out_eof   <= (w_col == COL_EOL) && (w_row == ROW_EOF);
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_sof_bad) begin
            r_sof_err <= 1'b1;
         end else if (err_clr) begin
            r_sof_err <= 1'b0;
         end
      end
   end

   // The shift window only moves on accept, so it stays frozen while a window is stalled.
   assign out_win = {r_bot[2], r_bot[1], r_bot[0],
                     r_mid[2], r_mid[1], r_mid[0],
                     r_top[2], r_top[1], r_top[0]};

   assign in_ready   = w_in_ready;
   assign out_valid  = r_out_valid;
   assign out_sof    = r_out_sof;
   assign out_eol    = r_out_eol;
   assign out_eof    = r_out_eof;
   assign frame_done = r_frame_done;
   assign sof_err    = r_sof_err;

endmodule

// File: tb/tb_window3x3_stream.sv
// Bench for window3x3_stream: a 4x4 stride-1 instance and a 4x4 stride-2 instance,
// ramp frames driven pixel by pixel, windows checked against a queue built from the image.
module tb_window3x3_stream;

   localparam int PW = 8;
   localparam int WW = 9*PW + 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid1 = 1'b0;
   logic          in_valid2 = 1'b0;
   logic          in_sof = 1'b0;
   logic          err_clr = 1'b0;
   logic [PW-1:0] in_pixel = '0;
   logic          out_ready1 = 1'b1;
   logic          out_ready2 = 1'b1;

   logic            in_ready1, out_valid1, sof1, eol1, eof1, fd1, serr1;
   logic            in_ready2, out_valid2, sof2, eol2, eof2, fd2, serr2;
   logic [9*PW-1:0] win1, win2;

   logic [WW-1:0] exp_q1[$];
   logic [WW-1:0] exp_q2[$];

   int n_checks = 0;
   int n_fail = 0;
   int win1_cnt = 0;
   int win2_cnt = 0;
   int fd1_cnt = 0;
   int fd2_cnt = 0;
   int stall_left = 0;
   bit stall_en = 1'b0;

   window3x3_stream #(.PIX_W(PW), .IMG_W(4), .IMG_H(4), .STRIDE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_pixel(in_pixel), .in_sof(in_sof), .out_valid(out_valid1), .out_ready(out_ready1),
      .out_win(win1), .out_sof(sof1), .out_eol(eol1), .out_eof(eof1),
      .frame_done(fd1), .sof_err(serr1), .err_clr(err_clr));

   window3x3_stream #(.PIX_W(PW), .IMG_W(4), .IMG_H(4), .STRIDE(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
      .in_pixel(in_pixel), .in_sof(in_sof), .out_valid(out_valid2), .out_ready(out_ready2),
      .out_win(win2), .out_sof(sof2), .out_eol(eol2), .out_eof(eof2),
      .frame_done(fd2), .sof_err(serr2), .err_clr(err_clr));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [PW-1:0] pv(input int r, input int c);
      return PW'(r*6 + c);
   endfunction

   // Expected window for pixel (r,c) of a 6x6 ramp, built straight from the image.
   task automatic model_push(input int which, input int r, input int c);
      int stride;
      int last;
      logic [9*PW-1:0] w;
      logic s, l, e;
      stride = which;
      last = (stride == 2) ? 4 : 5;
      if (r >= 2 && c >= 2 && ((r-2) % stride == 0) && ((c-2) % stride == 0)) begin
         w = '0;
         for (int k = 0; k < 9; k++) w[k*PW +: PW] = pv(r - 2 + k/3, c - 2 + k%3);
         s = (r == 2) && (c == 2);
         l = (c == last);
         e = l && (r == last);
         if (which == 1) exp_q1.push_back({e, l, s, w});
         else            exp_q2.push_back({e, l, s, w});
      end
   endtask

   task automatic drive_pix(input int which, input int r, input int c, input logic sof, input int gap);
      int guard;
      logic rdy;
      while (gap > 0 && $urandom_range(0, 99) < gap) @(negedge clk);
      in_pixel = pv(r, c);
      in_sof = sof;
      if (which == 1) in_valid1 = 1'b1;
      else            in_valid2 = 1'b1;
      #1;
      guard = 0;
      rdy = (which == 1) ? in_ready1 : in_ready2;
      while (!rdy && guard < 100) begin
         @(negedge clk);
         #1;
         guard++;
         rdy = (which == 1) ? in_ready1 : in_ready2;
      end
      if (guard >= 100) check("in_ready_timeout", rdy, 1);
      else model_push(which, r, c);
      @(negedge clk);
      in_valid1 = 1'b0;
      in_valid2 = 1'b0;
      in_sof = 1'b0;
   endtask

   task automatic drive_frame(input int which, input int gap);
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 6; c++)
            drive_pix(which, r, c, (r == 0 && c == 0), gap);
   endtask

   task automatic drain(input int which);
      int g;
      g = 0;
      while (((which == 1) ? exp_q1.size() : exp_q2.size()) > 0 && g < 50) begin
         @(negedge clk);
         g++;
      end
      check("drain_queue_empty", (which == 1) ? exp_q1.size() : exp_q2.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   // Output side: stall control for window 6, then pop/compare every handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         if (!out_ready1) begin
            check("stall_out_valid", out_valid1, 1);
            check("stall_in_ready", in_ready1, 0);
            check("stall_p5_held", win1[5*PW-1:4*PW], 14);
         end
         if (stall_en && stall_left > 0 && out_valid1 && win1_cnt == 5) begin
            out_ready1 = 1'b0;
            stall_left--;
         end else begin
            out_ready1 = 1'b1;
         end
         if (out_valid1 && out_ready1) begin
            check("win1_expected_present", exp_q1.size() > 0, 1);
            if (exp_q1.size() > 0) check("win1", {eof1, eol1, sof1, win1}, exp_q1.pop_front());
            win1_cnt++;
         end
         if (out_valid2 && out_ready2) begin
            check("win2_expected_present", exp_q2.size() > 0, 1);
            if (exp_q2.size() > 0) check("win2", {eof2, eol2, sof2, win2}, exp_q2.pop_front());
            win2_cnt++;
         end
         if (fd1) fd1_cnt++;
         if (fd2) fd2_cnt++;
      end
   end

   initial begin
      int fd_base;
      repeat (3) @(negedge clk);
      check("rst_out_valid", out_valid1, 0);
      check("rst_in_ready", in_ready1, 1);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_out_win", win1, 0);
      check("rst_flags", {sof1, eol1, eof1}, 0);
      check("rst_frame_done", fd1, 0);
      check("rst_sof_err", serr1, 0);
      check("rst_out_valid2", out_valid2, 0);

      // Ramp frame at full rate, with the first-window latency checked explicitly.
      win1_cnt = 0;
      fd_base = fd1_cnt;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 6; c++) begin
            drive_pix(1, r, c, (r == 0 && c == 0), 0);
            if (r == 2 && c == 1) check("lat_not_yet_valid", out_valid1, 0);
            if (r == 2 && c == 2) begin
               check("lat_first_valid", out_valid1, 1);
               check("lat_first_sof", sof1, 1);
            end
         end
      drain(1);
      check("s1_window_count", win1_cnt, 16);
      check("s1_frame_done", fd1_cnt - fd_base, 1);

      // Backpressure for 5 cycles at window 6.
      win1_cnt = 0;
      stall_left = 5;
      stall_en = 1'b1;
      fd_base = fd1_cnt;
      drive_frame(1, 0);
      drain(1);
      stall_en = 1'b0;
      check("s2_stall_done", stall_left, 0);
      check("s2_window_count", win1_cnt, 16);
      check("s2_frame_done", fd1_cnt - fd_base, 1);

      // Random input gaps.
      win1_cnt = 0;
      fd_base = fd1_cnt;
      drive_frame(1, 30);
      drain(1);
      check("s3_window_count", win1_cnt, 16);
      check("s3_frame_done", fd1_cnt - fd_base, 1);

      // Stride 2 instance.
      win2_cnt = 0;
      fd_base = fd2_cnt;
      drive_frame(2, 0);
      drain(2);
      check("s4_window_count", win2_cnt, 4);
      check("s4_frame_done", fd2_cnt - fd_base, 1);

      // Early start-of-frame at (1,3), then a complete frame from that pixel.
      for (int c = 0; c < 6; c++) drive_pix(1, 0, c, (c == 0), 0);
      for (int c = 0; c < 3; c++) drive_pix(1, 1, c, 1'b0, 0);
      check("s5_no_err_yet", serr1, 0);
      win1_cnt = 0;
      fd_base = fd1_cnt;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 6; c++) begin
            drive_pix(1, r, c, (r == 0 && c == 0), 0);
            if (r == 0 && c == 0) check("s5_sof_err_set", serr1, 1);
         end
      drain(1);
      check("s5_window_count", win1_cnt, 16);
      check("s5_frame_done", fd1_cnt - fd_base, 1);
      check("s5_err_sticky", serr1, 1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("s5_err_cleared", serr1, 0);

      // Back-to-back frames, then reset in the middle of a third.
      win1_cnt = 0;
      fd_base = fd1_cnt;
      drive_frame(1, 0);
      drive_frame(1, 0);
      drain(1);
      check("s6_window_count", win1_cnt, 32);
      check("s6_frame_done", fd1_cnt - fd_base, 2);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 6; c++)
            if (r < 2 || c <= 2) drive_pix(1, r, c, (r == 0 && c == 0), 0);
      check("s6_pending_valid", out_valid1, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("s6_reset_drops_valid", out_valid1, 0);
      check("s6_reset_in_ready", in_ready1, 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("s6_queue_empty_after_reset", exp_q1.size(), 0);
      win1_cnt = 0;
      fd_base = fd1_cnt;
      drive_frame(1, 0);
      drain(1);
      check("s6_post_reset_count", win1_cnt, 16);
      check("s6_post_reset_frame_done", fd1_cnt - fd_base, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
